matrix_result_drain: RTL and testbench
======================================

Name: matrix_result_drain

Overview:
Sink for the matrix_multiplier result port. Completes the out_ready/out_ack handshake and captures the flattened result matrix in one shot. Then streams the elements one 32-bit float at a time over a valid/ready interface, row-major, each tagged with row/col indices. It sits between matrix_multiplier and any word-serial consumer (UART packer, FIFO, bus writer).

Parameters:
NUM_ROW, 2, rows of result matrix (matrix_multiplier NUM_FIRST_ROW)
NUM_COL, 2, columns of result matrix (matrix_multiplier NUM_SECOND_COL)
WORD, 32, element width (IEEE-754 single)
Derived: TOTAL = NUM_ROW*NUM_COL*WORD; IDX_W = clog2(max(NUM_ROW,NUM_COL)), minimum 1

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
Out  input  TOTAL  flattened result from multiplier; element [r][c] at bits TOTAL-1-(r*NUM_COL+c)*WORD downto TOTAL-(r*NUM_COL+c+1)*WORD
out_ready  input  1  multiplier result valid; held with Out stable until out_ack seen
out_ack  output  1  capture acknowledge to multiplier
elem_data  output  WORD  current element
elem_row  output  IDX_W  row index of elem_data
elem_col  output  IDX_W  column index of elem_data
elem_last  output  1  high with final element (r=NUM_ROW-1, c=NUM_COL-1)
elem_valid  output  1  elem_* valid
elem_ready  input  1  downstream accepts when high with elem_valid
frame_done  output  1  one-cycle pulse after last element accepted
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, any state): state=IDLE. out_ack, elem_valid, elem_last, frame_done, busy = 0. elem_data, elem_row, elem_col = 0. Capture register cleared. An in-progress stream is aborted, with no partial frame_done.
- Four-phase handshake on result side: producer raises out_ready; drain raises out_ack; producer drops out_ready; drain drops out_ack.
- FSM states: IDLE, RELEASE, STREAM.
- IDLE: on the edge where out_ready=1, capture Out into the shadow register, set out_ack=1, busy=1, go to RELEASE. out_ack is therefore high 1 cycle after out_ready is first sampled high.
- RELEASE: hold out_ack=1 while out_ready=1. On the edge where out_ready=0: set out_ack=0, elem_valid=1, present element [0][0], go to STREAM.
- STREAM: elem_data, elem_row, elem_col and elem_last are stable while elem_valid & !elem_ready.
  - On elem_valid & elem_ready for a non-last element: advance to the next element in the same edge (col+1; wrap col to 0 and row+1 at NUM_COL-1). elem_valid stays 1, so there are no bubbles; full throughput is 1 element/cycle.
  - On acceptance of the last element: elem_valid=0, elem_last=0, frame_done=1 for exactly one cycle, state=IDLE, busy=0.
- out_ack is never high in STREAM. out_ready asserted during STREAM is ignored until IDLE.
  - If out_ready is high in the cycle frame_done pulses, it is sampled in IDLE on the following edge, giving a 1-cycle turnaround.
- Element data comes solely from the shadow register. Out may change freely after out_ack rises.
- Latency: out_ready rise to first elem_valid = 2 + N cycles, where N is the number of cycles out_ready stays high after out_ack rises. The frame completes in NUM_ROW*NUM_COL accepted transfers.
- Degenerate NUM_ROW=NUM_COL=1: first element has elem_last=1; a single accept ends the frame.
- No arithmetic on data; bits pass through unaltered.

Test Plan:
- 2x2 basic: Out={41D570A4,4138F5C2,41300000,40A00000} (hex). Raise out_ready, drop it 1 cycle after out_ack, elem_ready tied 1. Required: out_ack high 1 cycle after out_ready; 4 consecutive beats (0,0)=41D570A4, (0,1)=4138F5C2, (1,0)=41300000, (1,1)=40A00000; elem_last only on beat 4; frame_done pulses once; busy low afterwards.
- Backpressure: same data, elem_ready toggles 1,0,0,1,0,1,1. Required: elem_data/indices unchanged while elem_ready=0; exactly 4 accepted beats in order; no duplicates or skips.
- Late release: out_ready held 5 cycles after out_ack. Required: out_ack stays high for that span; elem_valid remains 0 until the cycle after out_ready is sampled low; Out changed to garbage after ack does not alter streamed data.
- Back-to-back frames: second out_ready raised during STREAM of frame 1. Required: no out_ack until frame 1 frame_done; frame 2 captured on the next edge; both frames stream intact.
- Reset mid-stream: assert rst asynchronously (not clock-aligned) after beat 2 is accepted. Required: all outputs 0 immediately; no frame_done. With out_ready then held high, a new capture occurs on the first edge after rst release.
- 3x2 parameterisation (NUM_ROW=3, NUM_COL=2, TOTAL=192): distinct words. Required: index sequence (0,0),(0,1),(1,0),(1,1),(2,0),(2,1); elem_last only on (2,1).

Source files
------------

// File: rtl/matrix_result_drain.sv
// matrix_result_drain
//   Sink for the matrix_multiplier result port. Completes the four-phase
//   out_ready/out_ack handshake, captures the flattened result matrix into a
//   shadow register in one shot, then streams its elements row-major, one
//   WORD at a time, over a valid/ready interface tagged with row/col indices.
//
// Ports
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   Out          : flattened result; element [r][c] occupies
//                  bits TOTAL-1-(r*NUM_COL+c)*WORD downto TOTAL-(r*NUM_COL+c+1)*WORD
//   out_ready    : producer result valid (held with Out until out_ack seen)
//   out_ack      : capture acknowledge back to the producer
//   elem_data    : current element
//   elem_row/col : indices of elem_data
//   elem_last    : high with the final element
//   elem_valid   : elem_* valid
//   elem_ready   : downstream accept
//   frame_done   : one-cycle pulse after the last element is accepted
//   busy         : high whenever the block is not idle
module matrix_result_drain #(
  parameter  int NUM_ROW = 2,
  parameter  int NUM_COL = 2,
  parameter  int WORD    = 32,
  localparam int TOTAL   = NUM_ROW * NUM_COL * WORD,
  localparam int IDX_MAX = (NUM_ROW > NUM_COL) ? NUM_ROW : NUM_COL,
  localparam int IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TOTAL-1:0] Out,
  input  logic             out_ready,
  output logic             out_ack,
  output logic [WORD-1:0]  elem_data,
  output logic [IDX_W-1:0] elem_row,
  output logic [IDX_W-1:0] elem_col,
  output logic             elem_last,
  output logic             elem_valid,
  input  logic             elem_ready,
  output logic             frame_done,
  output logic             busy
);

  localparam int unsigned NUM_ELEM = NUM_ROW * NUM_COL;
  localparam int unsigned NCOL_U   = NUM_COL;
  localparam int unsigned WORD_U   = WORD;
  localparam int unsigned TOTAL_U  = TOTAL;
  localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(NUM_ROW - 1);
  localparam logic [IDX_W-1:0] COL_LAST = IDX_W'(NUM_COL - 1);

  typedef enum logic [1:0] {
    IDLE,
    RELEASE,
    STREAM
  } state_t;

  state_t             state_q,  state_d;
  logic [TOTAL-1:0]   shadow_q, shadow_d;
  logic               ack_q,    ack_d;
  logic               valid_q,  valid_d;
  logic               last_q,   last_d;
  logic               done_q,   done_d;
  logic [IDX_W-1:0]   row_q,    row_d;
  logic [IDX_W-1:0]   col_q,    col_d;
  logic [WORD-1:0]    data_q,   data_d;

  // Successor position in row-major order and the word stored there.
  logic [IDX_W-1:0]   nxt_row;
  logic [IDX_W-1:0]   nxt_col;
  logic [31:0]        nxt_sel;
  logic [31:0]        nxt_shamt;
  logic [WORD-1:0]    nxt_word;
  logic [WORD-1:0]    first_word;

  always_comb begin
    nxt_row = row_q;
    nxt_col = col_q;
    if (col_q == COL_LAST) begin
      nxt_col = '0;
      nxt_row = row_q + 1'b1;
    end else begin
      nxt_col = col_q + 1'b1;
    end
    nxt_sel   = 32'(nxt_row) * NCOL_U + 32'(nxt_col);
    // Element k sits k words below the top of the vector; a shift keeps the
    // select index-width independent of the parameterisation.
    nxt_shamt  = TOTAL_U - (nxt_sel + 32'd1) * WORD_U;
    nxt_word   = WORD'(shadow_q >> nxt_shamt);
    first_word = WORD'(shadow_q >> (TOTAL_U - WORD_U));
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    ack_d    = ack_q;
    valid_d  = valid_q;
    last_d   = last_q;
    done_d   = 1'b0;
    row_d    = row_q;
    col_d    = col_q;
    data_d   = data_q;

    unique case (state_q)
      IDLE: begin
        if (out_ready) begin
          shadow_d = Out;
          ack_d    = 1'b1;
          state_d  = RELEASE;
        end
      end

      RELEASE: begin
        if (!out_ready) begin
          ack_d   = 1'b0;
          valid_d = 1'b1;
          row_d   = '0;
          col_d   = '0;
          data_d  = first_word;
          last_d  = (NUM_ELEM == 1);
          state_d = STREAM;
        end
      end

      STREAM: begin
        if (valid_q && elem_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            row_d  = nxt_row;
            col_d  = nxt_col;
            data_d = nxt_word;
            last_d = (nxt_row == ROW_LAST) && (nxt_col == COL_LAST);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      ack_q    <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      ack_q    <= ack_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      done_q   <= done_d;
      row_q    <= row_d;
      col_q    <= col_d;
      data_q   <= data_d;
    end
  end

  assign out_ack    = ack_q;
  assign elem_data  = data_q;
  assign elem_row   = row_q;
  assign elem_col   = col_q;
  assign elem_last  = last_q;
  assign elem_valid = valid_q;
  assign frame_done = done_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_matrix_result_drain.sv
// Directed bench for matrix_result_drain: a 2x2 instance covering handshake,
// streaming, backpressure, late release, back-to-back frames and async reset,
// plus a 3x2 instance for index sequencing.
module tb_matrix_result_drain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 2x2 instance
  logic [127:0] Out;
  logic         out_ready;
  logic         out_ack;
  logic [31:0]  elem_data;
  logic [0:0]   elem_row;
  logic [0:0]   elem_col;
  logic         elem_last;
  logic         elem_valid;
  logic         elem_ready;
  logic         frame_done;
  logic         busy;

  // 3x2 instance
  logic [191:0] out3;
  logic         out_ready3;
  logic         out_ack3;
  logic [31:0]  data3;
  logic [1:0]   row3;
  logic [1:0]   col3;
  logic         last3;
  logic         valid3;
  logic         ready3;
  logic         done3;
  logic         busy3;

  matrix_result_drain #(.NUM_ROW(2), .NUM_COL(2), .WORD(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .Out        (Out),
    .out_ready  (out_ready),
    .out_ack    (out_ack),
    .elem_data  (elem_data),
    .elem_row   (elem_row),
    .elem_col   (elem_col),
    .elem_last  (elem_last),
    .elem_valid (elem_valid),
    .elem_ready (elem_ready),
    .frame_done (frame_done),
    .busy       (busy)
  );

  matrix_result_drain #(.NUM_ROW(3), .NUM_COL(2), .WORD(32)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .Out        (out3),
    .out_ready  (out_ready3),
    .out_ack    (out_ack3),
    .elem_data  (data3),
    .elem_row   (row3),
    .elem_col   (col3),
    .elem_last  (last3),
    .elem_valid (valid3),
    .elem_ready (ready3),
    .frame_done (done3),
    .busy       (busy3)
  );

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;

  logic [127:0] frame_a = {32'h41D570A4, 32'h4138F5C2, 32'h41300000, 32'h40A00000};
  logic [127:0] frame_b = {32'h3F800000, 32'hBF800000, 32'h7F7FFFFF, 32'h00000001};
  logic [31:0]  words_a [4] = '{32'h41D570A4, 32'h4138F5C2, 32'h41300000, 32'h40A00000};
  logic [31:0]  words_b [4] = '{32'h3F800000, 32'hBF800000, 32'h7F7FFFFF, 32'h00000001};
  logic [31:0]  words_3 [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                                32'h40800000, 32'h40A00000, 32'h40C00000};
  logic [31:0]  exp_w [4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Capture phase with out_ready dropped as soon as out_ack is seen.
  task automatic start_frame(input logic [127:0] data, input string tag);
    Out       = data;
    out_ready = 1'b1;
    check({tag, "_ack_pre"}, 64'(out_ack), 64'd0);
    tick();
    check({tag, "_ack"}, 64'(out_ack), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_valid_cap"}, 64'(elem_valid), 64'd0);
    out_ready = 1'b0;
    tick();
    check({tag, "_ack_drop"}, 64'(out_ack), 64'd0);
    check({tag, "_valid_first"}, 64'(elem_valid), 64'd1);
  endtask

  // Streams a 2x2 frame against exp_w; rpat[p] is elem_ready in cycle p
  // (ready stays high past plen). Ends on the frame_done cycle.
  task automatic drain_frame(input logic [15:0] rpat, input int unsigned plen, input string tag);
    int unsigned b   = 0;
    int unsigned p   = 0;
    int unsigned cyc = 0;
    while (b < 4 && cyc < 50) begin
      elem_ready = (p < plen) ? rpat[p] : 1'b1;
      p++;
      check({tag, "_valid"}, 64'(elem_valid), 64'd1);
      check({tag, "_noack"}, 64'(out_ack), 64'd0);
      check({tag, "_nodone"}, 64'(frame_done), 64'd0);
      if (elem_valid) begin
        check({tag, "_data"}, 64'(elem_data), 64'(exp_w[b]));
        check({tag, "_row"}, 64'(elem_row), 64'(b / 2));
        check({tag, "_col"}, 64'(elem_col), 64'(b % 2));
        check({tag, "_last"}, 64'(elem_last), 64'(b == 3));
        if (elem_ready) b++;
      end
      tick();
      cyc++;
    end
    check({tag, "_beats"}, 64'(b), 64'd4);
    check({tag, "_done"}, 64'(frame_done), 64'd1);
    check({tag, "_valid_end"}, 64'(elem_valid), 64'd0);
    check({tag, "_last_end"}, 64'(elem_last), 64'd0);
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    Out        = '0;
    out_ready  = 1'b0;
    elem_ready = 1'b0;
    out3       = '0;
    out_ready3 = 1'b0;
    ready3     = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_ack",   64'(out_ack),    64'd0);
    check("rst_valid", 64'(elem_valid), 64'd0);
    check("rst_last",  64'(elem_last),  64'd0);
    check("rst_done",  64'(frame_done), 64'd0);
    check("rst_busy",  64'(busy),       64'd0);
    check("rst_data",  64'(elem_data),  64'd0);
    check("rst_idx",   64'({elem_row, elem_col}), 64'd0);
    check("rst3_busy", 64'(busy3),      64'd0);
    #2 rst = 1'b0;
    tick();

    // 2x2 basic, elem_ready tied high
    exp_w = words_a;
    elem_ready = 1'b1;
    start_frame(frame_a, "basic");
    drain_frame(16'hFFFF, 16, "basic");
    tick();
    check("basic_done_once", 64'(frame_done), 64'd0);
    check("basic_idle", 64'(busy), 64'd0);

    // Backpressure: ready pattern 1,0,0,1,0,1,1
    start_frame(frame_a, "bp");
    drain_frame(16'b1101001, 7, "bp");
    tick();
    check("bp_idle", 64'(busy), 64'd0);

    // Late release: out_ready held 5 cycles past out_ack, Out trashed
    Out       = frame_a;
    out_ready = 1'b1;
    tick();
    check("late_ack", 64'(out_ack), 64'd1);
    Out = {4{32'hDEADBEEF}};
    for (int i = 0; i < 5; i++) begin
      tick();
      check("late_ack_hold", 64'(out_ack), 64'd1);
      check("late_no_valid", 64'(elem_valid), 64'd0);
    end
    out_ready = 1'b0;
    tick();
    check("late_ack_drop", 64'(out_ack), 64'd0);
    check("late_valid", 64'(elem_valid), 64'd1);
    drain_frame(16'hFFFF, 16, "late");
    tick();

    // Back-to-back: frame 2 requested while frame 1 streams
    start_frame(frame_a, "b2b1");
    Out       = frame_b;
    out_ready = 1'b1;
    drain_frame(16'hFFFF, 16, "b2b1");
    tick();
    check("b2b_ack2", 64'(out_ack), 64'd1);
    check("b2b_busy2", 64'(busy), 64'd1);
    check("b2b_done_clr", 64'(frame_done), 64'd0);
    out_ready = 1'b0;
    tick();
    check("b2b_valid2", 64'(elem_valid), 64'd1);
    exp_w = words_b;
    drain_frame(16'hFFFF, 16, "b2b2");
    tick();
    check("b2b_idle", 64'(busy), 64'd0);

    // Reset mid-stream after two accepted beats
    exp_w = words_a;
    elem_ready = 1'b1;
    start_frame(frame_a, "mrst");
    tick();
    tick();
    check("mrst_beat2", 64'(elem_data), 64'h41300000);
    #3 rst = 1'b1;
    #1;
    check("mrst_ack",   64'(out_ack),    64'd0);
    check("mrst_valid", 64'(elem_valid), 64'd0);
    check("mrst_last",  64'(elem_last),  64'd0);
    check("mrst_done",  64'(frame_done), 64'd0);
    check("mrst_busy",  64'(busy),       64'd0);
    check("mrst_data",  64'(elem_data),  64'd0);
    check("mrst_idx",   64'({elem_row, elem_col}), 64'd0);
    Out        = frame_b;
    out_ready  = 1'b1;
    elem_ready = 1'b0;
    tick();
    check("mrst_hold_ack",  64'(out_ack),    64'd0);
    check("mrst_hold_done", 64'(frame_done), 64'd0);
    #2 rst = 1'b0;
    tick();
    check("mrst_recap_ack", 64'(out_ack), 64'd1);
    check("mrst_recap_done", 64'(frame_done), 64'd0);
    out_ready = 1'b0;
    tick();
    check("mrst_recap_valid", 64'(elem_valid), 64'd1);
    exp_w = words_b;
    drain_frame(16'hFFFF, 16, "mrst");
    tick();

    // 3x2 instance
    out3 = {words_3[0], words_3[1], words_3[2], words_3[3], words_3[4], words_3[5]};
    out_ready3 = 1'b1;
    ready3     = 1'b1;
    tick();
    check("m32_ack", 64'(out_ack3), 64'd1);
    out_ready3 = 1'b0;
    tick();
    begin
      int unsigned b   = 0;
      int unsigned cyc = 0;
      while (b < 6 && cyc < 20) begin
        check("m32_valid", 64'(valid3), 64'd1);
        if (valid3) begin
          check("m32_data", 64'(data3), 64'(words_3[b]));
          check("m32_row",  64'(row3),  64'(b / 2));
          check("m32_col",  64'(col3),  64'(b % 2));
          check("m32_last", 64'(last3), 64'(b == 5));
          b++;
        end
        tick();
        cyc++;
      end
      check("m32_beats", 64'(b), 64'd6);
    end
    check("m32_done", 64'(done3), 64'd1);
    check("m32_valid_end", 64'(valid3), 64'd0);
    tick();
    check("m32_done_clr", 64'(done3), 64'd0);
    check("m32_idle", 64'(busy3), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
